wb_single_master: RTL and testbench
===================================

// Module: wb_single_master
// PURPOSE
//  Wishbone classic-cycle initiator that turns one command-channel request into one
//  single-beat WB read or write. It waits for ack or timeout and returns the read data
//  and an error flag on a response channel. Test harnesses and LA-driven control logic
//  use it to reach the user-area WB slaves (0x3800_0000 BRAM window, delayed-ack
//  responders) without the management SoC.
// PARAMETERS
//  TIMEOUT     64  WB cycles waited for ack before abort; legal range 1..(2**TO_W)-1
//  TO_W        8   width of timeout counter
//  ERR_DATA    32'hDEAD_BEEF  rsp_dat value returned on timeout
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset, synchronous, active-high
//  cmd_valid   in   1   command present
//  cmd_ready   out  1   command accepted when cmd_valid & cmd_ready
//  cmd_we      in   1   1=write, 0=read
//  cmd_adr     in   32  byte address
//  cmd_dat     in   32  write data
//  cmd_sel     in   4   byte selects
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   response consumed when rsp_valid & rsp_ready
//  rsp_dat     out  32  read data (0 for completed writes, ERR_DATA on timeout)
//  rsp_err     out  1   1 = timeout abort
//  busy        out  1   high in REQ or RESP
//  wbm_cyc_o   out  1   WB cycle
//  wbm_stb_o   out  1   WB strobe (always equal to wbm_cyc_o)
//  wbm_we_o    out  1   WB write enable
//  wbm_sel_o   out  4   WB byte selects
//  wbm_adr_o   out  32  WB address
//  wbm_dat_o   out  32  WB write data
//  wbm_dat_i   in   32  WB read data
//  wbm_ack_i   in   1   WB ack
// BEHAVIOUR
//  Reset values: cyc/stb/we=0, sel=0, adr=0, dat_o=0, rsp_valid=0, rsp_dat=0,
//   rsp_err=0, cmd_ready=1, busy=0, state=IDLE, timeout counter=0.
//  FSM IDLE -> REQ -> RESP -> IDLE. All outputs are registered, except that
//   cmd_ready = (state==IDLE) and busy = (state!=IDLE).
//  IDLE: when cmd_valid is high in cycle N, latch we/adr/dat/sel onto the wbm_* outputs
//   and go to REQ. cyc=stb=1 from cycle N+1. wbm_dat_o is forced to 0 for reads.
//  REQ: cyc/stb/adr/sel/we/dat_o are held stable. The counter increments each cycle,
//   starting at 0 in the first REQ cycle.
//   - ack=1 sampled: capture rsp_dat = we ? 0 : wbm_dat_i and set rsp_err=0. Drop cyc/stb
//     and set rsp_valid=1 at the next edge, then go to RESP. If ack is sampled in cycle M,
//     rsp_valid is high in M+1.
//   - counter==TIMEOUT-1 and ack=0: drop cyc/stb, set rsp_dat=ERR_DATA, rsp_err=1,
//     rsp_valid=1, go to RESP.
//   - If ack and the timeout terminal count occur in the same cycle, ack wins (no error).
//  RESP: rsp_valid and rsp_dat/err are held until rsp_ready. On the handshake edge,
//   rsp_valid=0 and the FSM goes to IDLE. The next command is accepted one cycle later,
//   so there is at most one outstanding transaction.
//  ack outside REQ (stale or late ack after a timeout) is ignored and does not change
//   any state.
//  rst in any state: next edge restores all reset values. cyc/stb drop immediately and
//   any pending response is discarded.
//  cyc is never asserted for more than TIMEOUT consecutive cycles.
// STRUCTURE
//  Shared package wb_pkg holds the state encoding localparams (IDLE=2'd0, REQ=2'd1,
//   RESP=2'd2), the WB_DATA_W/WB_SEL_W widths, and the USER_BASE=32'h3800_0000 constant.
//  No sub-module: one FSM always block plus a TO_W-bit counter, all in this file.
// TESTING
//  1 Read, ack 11 cycles after stb (DELAYS=10 slave), adr 0x3800_0004 holding 0x1234_5678
//    -> cyc high exactly 11 cycles; rsp_dat=0x1234_5678, rsp_err=0 one cycle after ack.
//  2 Write adr 0x3800_0008 dat 0xA5A5_0F0F sel 4'hF, immediate ack -> wbm_dat_o/sel
//    stable while cyc is high; rsp_dat=0, rsp_err=0; a readback returns 0xA5A5_0F0F.
//  3 Read to an unmapped address (no ack), TIMEOUT=64 -> cyc high exactly 64 cycles;
//    rsp_err=1, rsp_dat=0xDEAD_BEEF; a late ack 3 cycles later is ignored.
//  4 rsp_ready held low 20 cycles -> rsp_valid/dat held; cmd_ready=0 and cmd_valid is
//    ignored throughout; the next command is accepted 1 cycle after the rsp handshake.
//  5 rst asserted on the 5th REQ cycle -> next edge cyc=stb=0, rsp_valid=0, cmd_ready=1;
//    a subsequent read completes normally.
//  6 ack arriving on the terminal timeout cycle (TIMEOUT=4, ack on the 4th REQ cycle)
//    -> rsp_err=0 and rsp_dat=wbm_dat_i.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : wb_pkg
//  Purpose : Shared Wishbone definitions for the user-area initiators:
//            bus widths, the user-area base address and the encoding of
//            the single-master FSM states.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    localparam logic [31:0] USER_BASE = 32'h3800_0000;

    // State encoding of the single-beat master FSM.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_REQ  = REQ,
        S_RESP = RESP
    } state_e;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_single_master.sv
`default_nettype none
// ============================================================================
//  Module  : wb_single_master
//  Purpose : Wishbone classic-cycle initiator. Converts one command-channel
//            request into one single-beat WB read or write, waits for ack
//            or a timeout, and returns read data plus an error flag on the
//            response channel. At most one transaction is outstanding.
//  Ports   :
//    clk, rst                 clock, synchronous active-high reset
//    cmd_valid/cmd_ready      command handshake (ready = FSM idle)
//    cmd_we/adr/dat/sel       command payload
//    rsp_valid/rsp_ready      response handshake
//    rsp_dat/rsp_err          read data (0 for writes, ERR_DATA on timeout)
//    busy                     FSM not idle
//    wbm_*                    Wishbone master interface (stb mirrors cyc)
//  Rev     : 1.0  initial release
// ============================================================================
module wb_single_master
    import wb_pkg::*;
#(
    parameter int          TIMEOUT  = 64,
    parameter int          TO_W     = 8,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [WB_DATA_W-1:0]  cmd_adr,
    input  logic [WB_DATA_W-1:0]  cmd_dat,
    input  logic [WB_SEL_W-1:0]   cmd_sel,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WB_DATA_W-1:0]  rsp_dat,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [WB_SEL_W-1:0]   wbm_sel_o,
    output logic [WB_DATA_W-1:0]  wbm_adr_o,
    output logic [WB_DATA_W-1:0]  wbm_dat_o,
    input  logic [WB_DATA_W-1:0]  wbm_dat_i,
    input  logic                  wbm_ack_i
);

    // Counter value seen in the last permitted REQ cycle.
    localparam logic [TO_W-1:0] c_TERM = TO_W'(TIMEOUT - 1);

    state_e                 r_state,     w_state_nxt;
    logic [TO_W-1:0]        r_cnt,       w_cnt_nxt;
    logic                   r_cyc,       w_cyc_nxt;
    logic                   r_we,        w_we_nxt;
    logic [WB_SEL_W-1:0]    r_sel,       w_sel_nxt;
    logic [WB_DATA_W-1:0]   r_adr,       w_adr_nxt;
    logic [WB_DATA_W-1:0]   r_dat_o,     w_dat_o_nxt;
    logic                   r_rsp_valid, w_rsp_valid_nxt;
    logic [WB_DATA_W-1:0]   r_rsp_dat,   w_rsp_dat_nxt;
    logic                   r_rsp_err,   w_rsp_err_nxt;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat_o     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cyc       <= w_cyc_nxt;
            r_we        <= w_we_nxt;
            r_sel       <= w_sel_nxt;
            r_adr       <= w_adr_nxt;
            r_dat_o     <= w_dat_o_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_dat   <= w_rsp_dat_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-output logic. Everything holds by default, which
    // is what keeps the bus stable in REQ and the response stable in RESP.
    // An ack outside REQ falls through to the defaults and is ignored.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_cyc_nxt       = r_cyc;
        w_we_nxt        = r_we;
        w_sel_nxt       = r_sel;
        w_adr_nxt       = r_adr;
        w_dat_o_nxt     = r_dat_o;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_dat_nxt   = r_rsp_dat;
        w_rsp_err_nxt   = r_rsp_err;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = S_REQ;
                    w_cnt_nxt   = '0;
                    w_cyc_nxt   = 1'b1;
                    w_we_nxt    = cmd_we;
                    w_sel_nxt   = cmd_sel;
                    w_adr_nxt   = cmd_adr;
                    w_dat_o_nxt = cmd_we ? cmd_dat : '0;
                end
            end

            S_REQ: begin
                w_cnt_nxt = r_cnt + TO_W'(1);
                // Ack is tested first so it wins over a simultaneous timeout.
                if (wbm_ack_i) begin
                    w_state_nxt     = S_RESP;
                    w_cyc_nxt       = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_dat_nxt   = r_we ? '0 : wbm_dat_i;
                    w_rsp_err_nxt   = 1'b0;
                end else if (r_cnt == c_TERM) begin
                    w_state_nxt     = S_RESP;
                    w_cyc_nxt       = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_dat_nxt   = ERR_DATA;
                    w_rsp_err_nxt   = 1'b1;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt     = S_IDLE;
                w_cyc_nxt       = 1'b0;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat_o;

endmodule : wb_single_master
`default_nettype wire

// File: tb/tb_wb_single_master.sv
`default_nettype none
// ============================================================================
//  Module  : tb_wb_single_master
//  Purpose : Self-checking bench for wb_single_master. A word-addressed
//            memory model in the user window acts as both WB slave and
//            reference; unmapped addresses never ack.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_wb_single_master;

    localparam int          TIMEOUT  = 64;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

    int n_tests = 0;
    int n_fail  = 0;

    bit [31:0] mem [bit [29:0]];

    always #5 clk = ~clk;

    wb_single_master #(
        .TIMEOUT  (TIMEOUT),
        .TO_W     (8),
        .ERR_DATA (ERR_DATA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit mapped(input logic [31:0] a);
        return a[31:12] == 20'h38000;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
    endfunction

    // One complete transaction. dly = cycles between stb and ack (ack is
    // sampled in REQ cycle dly+1); rwait = cycles rsp_ready is held low,
    // with a spurious cmd_valid applied throughout; late_ack pulses ack
    // during RESP and again once back in IDLE.
    task automatic run_txn(input string tag, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input int dly, input int rwait, input bit late_ack);
        bit          ack_ok;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_cyc;
        int          ncyc;
        bit          bus_ok;
        bit          hold_ok;
        logic [31:0] m;

        ack_ok = mapped(adr) && (dly + 1 <= TIMEOUT);
        if (ack_ok) begin
            exp_err = 1'b0;
            exp_cyc = dly + 1;
            exp_dat = we ? 32'h0 : mem_rd(adr);
        end else begin
            exp_err = 1'b1;
            exp_cyc = TIMEOUT;
            exp_dat = ERR_DATA;
        end

        chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        tick();
        cmd_valid = 1'b0;
        cmd_we    = ~we;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cmd_sel   = 4'($urandom);

        ncyc   = 0;
        bus_ok = 1'b1;
        while (wbm_cyc_o === 1'b1 && ncyc < 200) begin
            ncyc++;
            bus_ok &= (wbm_stb_o === 1'b1) && (wbm_we_o === we) && (wbm_adr_o === adr)
                   && (wbm_sel_o === sel) && (wbm_dat_o === (we ? dat : 32'h0))
                   && (busy === 1'b1) && (cmd_ready === 1'b0) && (rsp_valid === 1'b0);
            if (ack_ok && ncyc == dly + 1) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = we ? $urandom : mem_rd(adr);
            end
            tick();
            wbm_ack_i = 1'b0;
            wbm_dat_i = $urandom;
        end
        chk({tag, ".bus_stable"}, 32'(bus_ok), 32'd1);
        chk({tag, ".cyc_len"}, 32'(ncyc), 32'(exp_cyc));
        chk({tag, ".stb"}, 32'(wbm_stb_o), 32'd0);

        if (ack_ok && we) begin
            m = mem_rd(adr);
            for (int b = 0; b < 4; b++)
                if (sel[b]) m[b*8 +: 8] = dat[b*8 +: 8];
            mem[adr[31:2]] = m;
        end

        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".rsp_dat"}, rsp_dat, exp_dat);
        chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));

        hold_ok = 1'b1;
        for (int i = 0; i < rwait; i++) begin
            cmd_valid = 1'b1;
            if (late_ack && i == 2) wbm_ack_i = 1'b1;
            tick();
            wbm_ack_i = 1'b0;
            hold_ok &= (rsp_valid === 1'b1) && (rsp_dat === exp_dat) && (rsp_err === exp_err)
                    && (wbm_cyc_o === 1'b0) && (cmd_ready === 1'b0) && (busy === 1'b1);
        end
        cmd_valid = 1'b0;
        if (rwait > 0) chk({tag, ".rsp_hold"}, 32'(hold_ok), 32'd1);

        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, ".rsp_done"}, {30'h0, rsp_valid, cmd_ready}, 32'h1);

        if (late_ack) begin
            wbm_ack_i = 1'b1;
            tick();
            wbm_ack_i = 1'b0;
            chk({tag, ".idle_ack"}, {29'h0, wbm_cyc_o, rsp_valid, busy}, 32'h0);
        end
    endtask

    initial begin
        bit          we;
        logic [31:0] adr;
        int          r;
        int          dly;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        mem[30'(32'h3800_0004 >> 2)] = 32'h1234_5678;

        tick();
        tick();
        chk("reset.ctrl", {26'h0, wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err, busy}, 32'h0);
        chk("reset.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset.adr", wbm_adr_o, 32'h0);
        chk("reset.dat_o", wbm_dat_o, 32'h0);
        chk("reset.sel", 32'(wbm_sel_o), 32'h0);
        chk("reset.rsp_dat", rsp_dat, 32'h0);
        rst = 1'b0;
        tick();

        // Delayed-ack read, write + readback, timeout with late ack.
        run_txn("rd_dly10", 1'b0, 32'h3800_0004, 32'hFFFF_FFFF, 4'hF, 10, 0, 1'b0);
        run_txn("wr_imm",   1'b1, 32'h3800_0008, 32'hA5A5_0F0F, 4'hF, 0, 0, 1'b0);
        run_txn("rd_back",  1'b0, 32'h3800_0008, 32'h0,         4'hF, 0, 0, 1'b0);
        run_txn("rd_tmo",   1'b0, 32'h1000_0000, 32'h0,         4'hF, 1000, 5, 1'b1);

        // Long backpressure, then a command right after the handshake.
        run_txn("bp20",     1'b0, 32'h3800_0004, 32'h0,         4'hF, 2, 20, 1'b0);
        run_txn("after_bp", 1'b1, 32'h3800_0010, 32'h0BAD_CAFE, 4'h5, 1, 0, 1'b0);

        // Reset during the 5th REQ cycle.
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h1000_0040;
        cmd_sel   = 4'hF;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rstreq.cyc_before", 32'(wbm_cyc_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstreq.after", {28'h0, wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready}, 32'h1);
        run_txn("rd_post_rst", 1'b0, 32'h3800_0010, 32'h0, 4'hF, 3, 1, 1'b0);

        // Ack on the terminal timeout cycle wins.
        run_txn("ack_term", 1'b0, 32'h3800_0004, 32'h0, 4'hF, TIMEOUT - 1, 0, 1'b0);
        run_txn("ack_late1", 1'b0, 32'h3800_0004, 32'h0, 4'hF, TIMEOUT, 0, 1'b0);

        // Randomized traffic against the memory model.
        for (int t = 0; t < 24; t++) begin
            we  = 1'($urandom_range(0, 1));
            adr = USER_BASE_ADR(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 7) == 0) adr = 32'h2000_0000 | (adr & 32'hFFC);
            r = $urandom_range(0, 9);
            if (r == 9)      dly = TIMEOUT - 1;
            else if (r == 8) dly = TIMEOUT + 5;
            else             dly = $urandom_range(0, 6);
            run_txn($sformatf("rnd%0d", t), we, adr, $urandom, 4'($urandom_range(1, 15)),
                    dly, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic [31:0] USER_BASE_ADR(input logic [3:0] idx);
        return 32'h3800_0000 | {26'h0, idx, 2'b00};
    endfunction

endmodule : tb_wb_single_master
`default_nettype wire
